axi_lite_regbank_slave: RTL and testbench

- Parametrised AXI4-Lite slave with a real register bank. Successor to the stub slave that ties read data to 0.
- Provides NUM_REGS data-width registers with WSTRB byte enables, per-register read-only mask, SLVERR on illegal access and a programmable response delay.
- Sits behind the AXI interconnect as a bring-up/control register block. It exposes register contents and write pulses to fabric logic.

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/axi_lite_rsp_timer.sv | 30 +++
 rtl/axi_lite_regbank_slave.sv | 211 +++++++++++++++++++++
 tb/tb_axi_lite_regbank_slave.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes, channel state encodings and a constant-safe clog2
// for the AXI4-Lite register bank slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_rsp_timer.sv
// Response-delay counter: loads DELAY on a handshake and counts down to zero.
// done flags that the response becomes valid on the following cycle.
module axi_lite_rsp_timer
  import axi_lite_pkg::*;
#(
  parameter int unsigned DELAY = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int unsigned CW = (clog2(DELAY + 1) > 0) ? clog2(DELAY + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(DELAY);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt <= CW'(1));

endmodule

// File: rtl/axi_lite_regbank_slave.sv
// AXI4-Lite slave with NUM_REGS byte-writable registers, read-only passthrough
// registers, SLVERR on illegal access and a fixed response delay per channel.
module axi_lite_regbank_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned RESP_DELAY = 0
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                                   S_AXI_AWVALID,
  input  logic [2:0]                             S_AXI_AWPROT,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                                   S_AXI_ARVALID,
  input  logic [2:0]                             S_AXI_ARPROT,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned NB       = DW / 8;
  localparam int unsigned ADDR_LSB = clog2(NB);
  localparam int unsigned IDXW     = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1;
  localparam int unsigned DEC_BITS = ADDR_LSB + IDXW;

  // Legal when the index names an existing register and no bit above the
  // decoded field is set, so large addresses never alias onto the bank.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic ok;
    logic [IDXW-1:0] ix;
    ok = 1'b1;
    ix = a[ADDR_LSB +: IDXW];
    if (32'(ix) >= NUM_REGS) ok = 1'b0;
    for (int unsigned b = DEC_BITS; b < AW; b++) begin
      if (a[b]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic idx_ro(input logic [IDXW-1:0] ix);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ix == IDXW'(i)) r = RO_MASK[i];
    end
    return r;
  endfunction

  w_state_e w_state, w_next;
  r_state_e r_state, r_next;

  logic            aw_hs, ar_hs;
  logic            w_legal, r_ok;
  logic            w_tdone, r_tdone;
  logic [IDXW-1:0] w_idx, r_idx;
  logic [DW-1:0]   rd_word;

  assign w_idx   = S_AXI_AWADDR[ADDR_LSB +: IDXW];
  assign w_legal = addr_ok(S_AXI_AWADDR) && !idx_ro(w_idx);
  assign r_idx   = S_AXI_ARADDR[ADDR_LSB +: IDXW];
  assign r_ok    = addr_ok(S_AXI_ARADDR);

  // ---------------- write channel ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) w_state <= W_IDLE;
    else                w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    aw_hs         = 1'b0;
    S_AXI_BVALID  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        aw_hs = S_AXI_AWVALID && S_AXI_WVALID && S_AXI_ARESETN;
        if (aw_hs) w_next = (RESP_DELAY == 0) ? W_RESP : W_WAIT;
      end
      W_WAIT: begin
        if (w_tdone) w_next = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign S_AXI_AWREADY = aw_hs;
  assign S_AXI_WREADY  = aw_hs;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_BRESP <= RESP_OKAY;
    end else if (aw_hs) begin
      S_AXI_BRESP <= w_legal ? RESP_OKAY : RESP_SLVERR;
    end
  end

  axi_lite_rsp_timer #(.DELAY(RESP_DELAY)) u_wtimer (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .load  (aw_hs),
    .done  (w_tdone)
  );

  // ---------------- register bank ----------------
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic hit;
    assign hit = aw_hs && w_legal && (w_idx == IDXW'(g));

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) reg_wr_pulse[g] <= 1'b0;
      else                reg_wr_pulse[g] <= hit;
    end

    if (RO_MASK[g]) begin : g_ro
      assign reg_out[g*DW +: DW] = ro_in[g*DW +: DW];
    end else begin : g_rw
      logic [DW-1:0] q;
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
          q <= RESET_VAL;
        end else if (hit) begin
          for (int unsigned b = 0; b < NB; b++) begin
            if (S_AXI_WSTRB[b]) q[b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
          end
        end
      end
      assign reg_out[g*DW +: DW] = q;
    end
  end

  // ---------------- read channel ----------------
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (r_idx == IDXW'(i)) rd_word = reg_out[i*DW +: DW];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= R_IDLE;
    else                r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    ar_hs         = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = S_AXI_ARESETN;
        ar_hs         = S_AXI_ARVALID && S_AXI_ARESETN;
        if (ar_hs) r_next = (RESP_DELAY == 0) ? R_RESP : R_WAIT;
      end
      R_WAIT: begin
        if (r_tdone) r_next = R_RESP;
      end
      R_RESP: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Captured from the pre-edge bank, so a same-cycle write is not visible.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RDATA <= r_ok ? rd_word : '0;
      S_AXI_RRESP <= r_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  axi_lite_rsp_timer #(.DELAY(RESP_DELAY)) u_rtimer (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .load  (ar_hs),
    .done  (r_tdone)
  );

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, ro_in,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi_lite_regbank_slave.sv
// Directed bench: vector table on a zero-delay instance, hand sequences for
// response delay, back-pressure and mid-transaction reset on a delay-3 instance.
module tb_axi_lite_regbank_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [2:0]    awprot, arprot;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic [NR*DW-1:0] ro_in;
  logic          sel;

  logic          aw0, w0, bv0, ar0, rv0, aw3, w3, bv3, ar3, rv3;
  logic [1:0]    br0, rr0, br3, rr3;
  logic [31:0]   rd0, rd3;
  logic [NR*DW-1:0] ro0, ro3;
  logic [NR-1:0] p0, p3;

  logic          awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
  logic [1:0]    bresp_s, rresp_s;
  logic [31:0]   rdata_s;
  logic [NR-1:0] pulse_s;

  assign awready_s = sel ? aw3 : aw0;
  assign wready_s  = sel ? w3  : w0;
  assign bvalid_s  = sel ? bv3 : bv0;
  assign bresp_s   = sel ? br3 : br0;
  assign arready_s = sel ? ar3 : ar0;
  assign rvalid_s  = sel ? rv3 : rv0;
  assign rresp_s   = sel ? rr3 : rr0;
  assign rdata_s   = sel ? rd3 : rd0;
  assign pulse_s   = sel ? p3  : p0;

  always #5 clk = ~clk;

  axi_lite_regbank_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(16), .NUM_REGS(16),
    .RO_MASK(16'h0002), .RESET_VAL(32'h0), .RESP_DELAY(0)
  ) dut0 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWPROT(awprot), .S_AXI_AWREADY(aw0),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(w0),
    .S_AXI_BRESP(br0), .S_AXI_BVALID(bv0), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARPROT(arprot), .S_AXI_ARREADY(ar0),
    .S_AXI_RDATA(rd0), .S_AXI_RRESP(rr0), .S_AXI_RVALID(rv0), .S_AXI_RREADY(rready),
    .reg_out(ro0), .ro_in(ro_in), .reg_wr_pulse(p0)
  );

  axi_lite_regbank_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(16), .NUM_REGS(16),
    .RO_MASK(16'h0002), .RESET_VAL(32'h0), .RESP_DELAY(3)
  ) dut3 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWPROT(awprot), .S_AXI_AWREADY(aw3),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(w3),
    .S_AXI_BRESP(br3), .S_AXI_BVALID(bv3), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARPROT(arprot), .S_AXI_ARREADY(ar3),
    .S_AXI_RDATA(rd3), .S_AXI_RRESP(rr3), .S_AXI_RVALID(rv3), .S_AXI_RREADY(rready),
    .reg_out(ro3), .ro_in(ro_in), .reg_wr_pulse(p3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat,
                           output logic [NR-1:0] pl1, output logic [NR-1:0] pl2);
    bit got;
    resp = 2'bxx; lat = -1; pl1 = 'x; pl2 = 'x;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (awready_s && wready_s) got = 1'b1;
      else tick();
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    if (!got) return;
    got = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) pl1 = pulse_s;
      if (k == 2) pl2 = pulse_s;
      if (!got && bvalid_s) begin got = 1'b1; lat = k; resp = bresp_s; end
      if (got && k >= 2) break;
      tick();
    end
    tick();
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    bit got;
    d = 'x; resp = 2'bxx; lat = -1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (arready_s) got = 1'b1;
      else tick();
    end
    tick();
    arvalid = 1'b0;
    if (!got) return;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rvalid_s) begin lat = k; d = rdata_s; resp = rresp_s; break; end
      tick();
    end
    tick();
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [15:0] exp_pulse;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt[18];
    logic [1:0]  resp;
    logic [31:0] rdv;
    logic [NR-1:0] pl1, pl2;
    int          lat;
    bit          got;

    vt[0]  = '{1'b1, 16'h0008, 32'hA5A5_1234, 4'hF, 2'b00, 32'h0,         16'h0004};
    vt[1]  = '{1'b0, 16'h0008, 32'h0,         4'h0, 2'b00, 32'hA5A5_1234, 16'h0};
    vt[2]  = '{1'b1, 16'h000C, 32'h1122_3344, 4'hF, 2'b00, 32'h0,         16'h0008};
    vt[3]  = '{1'b1, 16'h000C, 32'hFFFF_FFFF, 4'h5, 2'b00, 32'h0,         16'h0008};
    vt[4]  = '{1'b0, 16'h000C, 32'h0,         4'h0, 2'b00, 32'h11FF_33FF, 16'h0};
    vt[5]  = '{1'b1, 16'h0004, 32'h0,         4'hF, 2'b10, 32'h0,         16'h0};
    vt[6]  = '{1'b0, 16'h0004, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 16'h0};
    vt[7]  = '{1'b0, 16'h0040, 32'h0,         4'h0, 2'b10, 32'h0,         16'h0};
    vt[8]  = '{1'b1, 16'h0040, 32'h1234_5678, 4'hF, 2'b10, 32'h0,         16'h0};
    vt[9]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 2'b00, 32'h0,         16'h0};
    vt[10] = '{1'b1, 16'h0010, 32'hCAFE_F00D, 4'h0, 2'b00, 32'h0,         16'h0010};
    vt[11] = '{1'b0, 16'h0010, 32'h0,         4'h0, 2'b00, 32'h0,         16'h0};
    vt[12] = '{1'b0, 16'h000B, 32'h0,         4'h0, 2'b00, 32'hA5A5_1234, 16'h0};
    vt[13] = '{1'b1, 16'h1008, 32'h0,         4'hF, 2'b10, 32'h0,         16'h0};
    vt[14] = '{1'b0, 16'h0008, 32'h0,         4'h0, 2'b00, 32'hA5A5_1234, 16'h0};
    vt[15] = '{1'b1, 16'h003C, 32'h8765_4321, 4'h3, 2'b00, 32'h0,         16'h8000};
    vt[16] = '{1'b0, 16'h003C, 32'h0,         4'h0, 2'b00, 32'h0000_4321, 16'h0};
    vt[17] = '{1'b0, 16'h1000, 32'h0,         4'h0, 2'b10, 32'h0,         16'h0};

    ro_in = '0;
    ro_in[1*DW +: DW] = 32'hDEAD_BEEF;
    awprot = 3'b0; arprot = 3'b0;
    awaddr = 16'h0008; araddr = 16'h0008; wdata = 32'h1; wstrb = 4'hF;
    sel = 1'b0; rst_n = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;

    // Ready outputs must stay low while held in reset even with valids asserted.
    @(negedge clk);
    chk("rst_awready", aw0, 1'b0);
    chk("rst_arready", ar0, 1'b0);
    chk("rst_bvalid",  bv0, 1'b0);
    chk("rst_rvalid",  rv0, 1'b0);
    chk("rst_rdata",   rd0, 32'h0);
    chk("rst_reg2",    ro0[2*DW +: DW], 32'h0);
    chk("rst_pulse",   p0, 16'h0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, resp, lat, pl1, pl2);
        chk($sformatf("v%0d_bresp", i), resp, vt[i].exp_resp);
        chk($sformatf("v%0d_blat", i), lat, 1);
        chk($sformatf("v%0d_pulse", i), pl1, vt[i].exp_pulse);
        chk($sformatf("v%0d_pulse_end", i), pl2, 16'h0);
      end else begin
        axi_read(vt[i].addr, rdv, resp, lat);
        chk($sformatf("v%0d_rresp", i), resp, vt[i].exp_resp);
        chk($sformatf("v%0d_rdata", i), rdv, vt[i].exp_rdata);
        chk($sformatf("v%0d_rlat", i), lat, 1);
      end
    end
    chk("regout_2", ro0[2*DW +: DW], 32'hA5A5_1234);
    chk("regout_3", ro0[3*DW +: DW], 32'h11FF_33FF);

    // Same-cycle read and write to reg 2: read returns the old value.
    awaddr = 16'h0008; wdata = 32'h0BAD_F00D; wstrb = 4'hF; araddr = 16'h0008;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("rw_same_awready", aw0, 1'b1);
    chk("rw_same_arready", ar0, 1'b1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("rw_same_rvalid", rv0, 1'b1);
    chk("rw_same_rdata", rd0, 32'hA5A5_1234);
    chk("rw_same_bvalid", bv0, 1'b1);
    chk("rw_same_regout", ro0[2*DW +: DW], 32'h0BAD_F00D);
    tick();

    // Switch to the delay-3 instance from a clean reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sel = 1'b1;
    tick();

    // Delayed B response under back-pressure; AW must be refused while BVALID waits.
    awaddr = 16'h0014; wdata = 32'h0000_5A5A; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (awready_s) got = 1'b1;
      else tick();
    end
    chk("dly_aw_accept", got, 1'b1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("dly_bvalid_low_t%0d", k), bvalid_s, 1'b0);
      if (k == 1) chk("dly_pulse", pulse_s, 16'h0020);
      tick();
    end
    awaddr = 16'h0018; wdata = 32'h0000_0077; awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("dly_bvalid_hold%0d", k), bvalid_s, 1'b1);
      chk($sformatf("dly_bresp_hold%0d", k), bresp_s, 2'b00);
      chk($sformatf("dly_aw_blocked%0d", k), awready_s, 1'b0);
      tick();
    end
    bready = 1'b1;
    tick();
    @(negedge clk);
    chk("dly_next_accept", awready_s, 1'b1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bvalid_s) begin lat = k; break; end
      tick();
    end
    chk("dly_second_blat", lat, 4);
    tick();
    axi_read(16'h0018, rdv, resp, lat);
    chk("dly_rd6_data", rdv, 32'h77);
    chk("dly_rd6_lat", lat, 4);
    axi_read(16'h0014, rdv, resp, lat);
    chk("dly_rd5_data", rdv, 32'h5A5A);
    chk("dly_rd5_resp", resp, 2'b00);

    // Reset pulsed two cycles after the AW handshake drops the response.
    awaddr = 16'h001C; wdata = 32'h0000_1234; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (awready_s) got = 1'b1;
      else tick();
    end
    chk("rst_mid_accept", got, 1'b1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("rst_mid_reg7_written", ro3[7*DW +: DW], 32'h1234);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_reg7", ro3[7*DW +: DW], 32'h0);
    chk("rst_mid_reg5", ro3[5*DW +: DW], 32'h0);
    chk("rst_mid_reg6", ro3[6*DW +: DW], 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_bvalid_in%0d", k), bvalid_s, 1'b0);
      tick();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_bvalid_after%0d", k), bvalid_s, 1'b0);
      tick();
    end
    axi_write(16'h001C, 32'h0000_BEEF, 4'hF, resp, lat, pl1, pl2);
    chk("post_rst_bresp", resp, 2'b00);
    chk("post_rst_blat", lat, 4);
    chk("post_rst_pulse", pl1, 16'h0080);
    axi_read(16'h001C, rdv, resp, lat);
    chk("post_rst_rdata", rdv, 32'hBEEF);
    chk("post_rst_rlat", lat, 4);
    axi_read(16'h0014, rdv, resp, lat);
    chk("post_rst_reg5", rdv, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
